vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_if.sv | 29 ++
 rtl/vga_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_if.sv
// Pixel-stream bundle between the VGA timing controller (master) and the
// test-pattern generator (slave).
interface vga_pattern_if #(
   parameter int unsigned COLOR_W = 4,
   parameter int unsigned FRAME_W = 8
);
   logic               DE;
   logic [9:0]         x_pixel;
   logic [9:0]         y_pixel;
   logic [1:0]         mode_req;
   logic               mode_req_valid;
   logic [1:0]         mode_active;
   logic               frame_tick;
   logic [FRAME_W-1:0] frame_cnt;
   logic               de_out;
   logic [COLOR_W-1:0] r_port;
   logic [COLOR_W-1:0] g_port;
   logic [COLOR_W-1:0] b_port;

   modport master (
      output DE, x_pixel, y_pixel, mode_req, mode_req_valid,
      input  mode_active, frame_tick, frame_cnt, de_out, r_port, g_port, b_port
   );

   modport slave (
      input  DE, x_pixel, y_pixel, mode_req, mode_req_valid,
      output mode_active, frame_tick, frame_cnt, de_out, r_port, g_port, b_port
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// Two-stage pipelined VGA test-pattern generator: colour bars, grey ramp,
// checkerboard and scrolling bars, with frame-synchronous mode switching.
module vga_pattern_gen #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned COLOR_W     = 4,
   parameter int unsigned NUM_BARS    = 8,
   parameter int unsigned RAMP_SHIFT  = 5,
   parameter int unsigned CHECK_LOG2  = 5,
   parameter int unsigned SCROLL_STEP = 2,
   parameter int unsigned FRAME_W     = 8
) (
   input logic          clk,
   input logic          reset_n,
   vga_pattern_if.slave bus
);
   localparam int unsigned BAR_W   = H_ACTIVE / NUM_BARS;
   localparam int unsigned XHI_W   = 10 - RAMP_SHIFT;
   localparam int unsigned LVL_MAX = (2 ** COLOR_W) - 1;

   if (NUM_BARS < 1 || NUM_BARS > H_ACTIVE || SCROLL_STEP >= H_ACTIVE ||
       H_ACTIVE > 1024 || V_ACTIVE > 1024 || RAMP_SHIFT > 9 || CHECK_LOG2 > 9) begin : g_param_check
      $error("vga_pattern_gen: parameter out of range");
   end

   logic               frame_start_c;
   logic [1:0]         pending;
   logic [1:0]         mode_q;
   logic [9:0]         offset_q;
   logic [FRAME_W-1:0] fcnt_q;

   logic [1:0]  mode_c;
   logic [10:0] step_sum_c;
   logic [9:0]  offset_c;
   logic [10:0] x_sum_c;
   logic [9:0]  x_eff_c;
   logic [9:0]  bar_cnt_c;

   logic             s1_de, s1_fs, s1_xchk, s1_ychk;
   logic [1:0]       s1_mode;
   logic [2:0]       s1_idx;
   logic [XHI_W-1:0] s1_xhi;

   logic [COLOR_W-1:0] r_c, g_c, b_c;
   logic [COLOR_W-1:0] r_q, g_q, b_q;
   logic               de_q, tick_q;

   assign frame_start_c = bus.DE && (bus.x_pixel == 10'd0) && (bus.y_pixel == 10'd0);

   // The frame-start pixel already renders with the mode/offset being applied.
   always_comb begin
      step_sum_c = {1'b0, offset_q} + 11'(SCROLL_STEP);
      if (step_sum_c >= 11'(H_ACTIVE))
         step_sum_c = step_sum_c - 11'(H_ACTIVE);
      mode_c   = mode_q;
      offset_c = offset_q;
      if (frame_start_c) begin
         mode_c   = pending;
         offset_c = (pending == 2'd3) ? 10'(step_sum_c) : 10'd0;
      end
      x_sum_c = {1'b0, bus.x_pixel} + ((mode_c == 2'd3) ? {1'b0, offset_c} : 11'd0);
      if (x_sum_c >= 11'(H_ACTIVE))
         x_sum_c = x_sum_c - 11'(H_ACTIVE);
      x_eff_c = 10'(x_sum_c);
   end

   // Bar index counts crossed boundaries, so remainder pixels fall in the last bar.
   always_comb begin
      bar_cnt_c = 10'd0;
      for (int unsigned k = 1; k < NUM_BARS; k++) begin
         if (32'(x_eff_c) >= k * BAR_W)
            bar_cnt_c = bar_cnt_c + 10'd1;
      end
   end

   function automatic logic [2:0] palette(input logic [2:0] idx);
      case (idx)
         3'd0:    return 3'b111;
         3'd1:    return 3'b110;
         3'd2:    return 3'b011;
         3'd3:    return 3'b010;
         3'd4:    return 3'b101;
         3'd5:    return 3'b100;
         3'd6:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // Stage-2 colour selection; blanked pixels are forced to black.
   always_comb begin
      logic [2:0] pal;
      pal = palette(s1_idx);
      r_c = '0;
      g_c = '0;
      b_c = '0;
      case (s1_mode)
         2'd1: begin
            r_c = (32'(s1_xhi) > LVL_MAX) ? {COLOR_W{1'b1}} : COLOR_W'(s1_xhi);
            g_c = r_c;
            b_c = r_c;
         end
         2'd2: begin
            r_c = {COLOR_W{s1_xchk ^ s1_ychk}};
            g_c = r_c;
            b_c = r_c;
         end
         default: begin
            r_c = {COLOR_W{pal[2]}};
            g_c = {COLOR_W{pal[1]}};
            b_c = {COLOR_W{pal[0]}};
         end
      endcase
      if (!s1_de) begin
         r_c = '0;
         g_c = '0;
         b_c = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending  <= 2'd0;
         mode_q   <= 2'd0;
         offset_q <= 10'd0;
         fcnt_q   <= '0;
         s1_de    <= 1'b0;
         s1_fs    <= 1'b0;
         s1_xchk  <= 1'b0;
         s1_ychk  <= 1'b0;
         s1_mode  <= 2'd0;
         s1_idx   <= 3'd0;
         s1_xhi   <= '0;
         de_q     <= 1'b0;
         tick_q   <= 1'b0;
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
      end else begin
         if (bus.mode_req_valid)
            pending <= bus.mode_req;
         mode_q   <= mode_c;
         offset_q <= offset_c;
         if (frame_start_c)
            fcnt_q <= fcnt_q + FRAME_W'(1);
         s1_de   <= bus.DE;
         s1_fs   <= frame_start_c;
         s1_xchk <= bus.x_pixel[CHECK_LOG2];
         s1_ychk <= bus.y_pixel[CHECK_LOG2];
         s1_mode <= mode_c;
         s1_idx  <= bar_cnt_c[2:0];
         s1_xhi  <= bus.x_pixel[9:RAMP_SHIFT];
         de_q    <= s1_de;
         tick_q  <= s1_fs;
         r_q     <= r_c;
         g_q     <= g_c;
         b_q     <= b_c;
      end
   end

   assign bus.mode_active = mode_q;
   assign bus.frame_cnt   = fcnt_q;
   assign bus.frame_tick  = tick_q;
   assign bus.de_out      = de_q;
   assign bus.r_port      = r_q;
   assign bus.g_port      = g_q;
   assign bus.b_port      = b_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: directed test-plan pixels plus
// randomized traffic checked against an arithmetic reference model.
module tb_vga_pattern_gen;
   localparam int H  = 640;
   localparam int V  = 480;
   localparam int CW = 4;
   localparam int NB = 8;
   localparam int RS = 5;
   localparam int CL = 5;
   localparam int SS = 2;
   localparam int FW = 8;
   localparam int BAR_W = H / NB;

   typedef struct {
      int          due;
      logic [13:0] v;     // {de, tick, rgb}
      bit          spot;
   } pix_t;

   typedef struct {
      int          due;
      logic [9:0]  v;     // {mode_active, frame_cnt}
   } st_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   vga_pattern_if #(.COLOR_W(CW), .FRAME_W(FW)) bus ();

   vga_pattern_gen #(
      .H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(CW), .NUM_BARS(NB),
      .RAMP_SHIFT(RS), .CHECK_LOG2(CL), .SCROLL_STEP(SS), .FRAME_W(FW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   pix_t pq[$];
   st_t  sq[$];
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;

   int m_pend = 0, m_mode = 0, m_off = 0, m_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Colour from the pattern rules using plain division/modulo.
   function automatic logic [11:0] ref_rgb(input int mode, input int off, input int x, input int y);
      int xe, b, lvl;
      logic [2:0] c;
      logic [11:0] res;
      case (mode)
         1: begin
            lvl = x >> RS;
            if (lvl > 15) lvl = 15;
            res = {4'(lvl), 4'(lvl), 4'(lvl)};
         end
         2: res = ((((x >> CL) & 1) ^ ((y >> CL) & 1)) != 0) ? 12'hFFF : 12'h000;
         default: begin
            xe = (mode == 3) ? (x + off) % H : x;
            b = xe / BAR_W;
            if (b > NB - 1) b = NB - 1;
            case (b % 8)
               0: c = 3'b111;
               1: c = 3'b110;
               2: c = 3'b011;
               3: c = 3'b010;
               4: c = 3'b101;
               5: c = 3'b100;
               6: c = 3'b001;
               default: c = 3'b000;
            endcase
            res = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
         end
      endcase
      return res;
   endfunction

   task automatic step(input bit de, input int x, input int y, input int req, input bit reqv,
                       input bit spot, input logic [11:0] exp_rgb);
      bit fs;
      logic [11:0] rgb;
      @(posedge clk);
      #1;
      reset_n            = 1'b1;
      bus.DE             = de;
      bus.x_pixel        = 10'(x);
      bus.y_pixel        = 10'(y);
      bus.mode_req       = 2'(req);
      bus.mode_req_valid = reqv;
      fs = de && (x == 0) && (y == 0);
      if (fs) begin
         m_mode = m_pend;
         m_off  = (m_pend == 3) ? (m_off + SS) % H : 0;
         m_cnt  = (m_cnt + 1) % (1 << FW);
      end
      if (reqv) m_pend = req;
      if (spot)    rgb = exp_rgb;
      else if (de) rgb = ref_rgb(m_mode, m_off, x, y);
      else         rgb = 12'h000;
      pq.push_back('{cyc + 2, {de, fs, rgb}, spot});
      sq.push_back('{cyc + 1, {2'(m_mode), 8'(m_cnt)}});
   endtask

   task automatic spot_pix(input int x, input int y, input logic [11:0] exp_rgb);
      step(1'b1, x, y, 0, 1'b0, 1'b1, exp_rgb);
   endtask

   task automatic rnd_pix(input int ymin);
      step($urandom_range(0, 9) != 0, $urandom_range(0, H - 1), $urandom_range(ymin, V - 1),
           0, 1'b0, 1'b0, 12'h000);
   endtask

   task automatic frame_start();
      step(1'b1, 0, 0, 0, 1'b0, 1'b0, 12'h000);
   endtask

   task automatic request(input int req);
      step(1'b1, $urandom_range(1, H - 1), $urandom_range(1, V - 1), req, 1'b1, 1'b0, 12'h000);
   endtask

   // Holds reset n cycles; in-flight expectations are dropped and zeros expected.
   task automatic do_reset(input int n);
      int c;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      c = cyc;
      while (pq.size() > 0 && pq[$].due > c) void'(pq.pop_back());
      while (sq.size() > 0 && sq[$].due > c) void'(sq.pop_back());
      m_pend = 0; m_mode = 0; m_off = 0; m_cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         bus.DE             = 1'($urandom_range(0, 1));
         bus.x_pixel        = 10'($urandom_range(0, H - 1));
         bus.y_pixel        = 10'($urandom_range(0, V - 1));
         bus.mode_req       = 2'($urandom_range(0, 3));
         bus.mode_req_valid = 1'($urandom_range(0, 1));
         pq.push_back('{cyc + 1, 14'h0, 1'b0});
         sq.push_back('{cyc + 1, 10'h0});
         if (i == n - 1) pq.push_back('{cyc + 2, 14'h0, 1'b0});
      end
   endtask

   pix_t mp;
   st_t  ms;
   logic [13:0] got_pix;
   logic [9:0]  got_st;

   always @(negedge clk) begin
      got_pix = {bus.de_out, bus.frame_tick, bus.r_port, bus.g_port, bus.b_port};
      got_st  = {bus.mode_active, bus.frame_cnt};
      while (pq.size() > 0 && pq[0].due <= cyc) begin
         mp = pq.pop_front();
         compared++;
         if (mp.due != cyc || got_pix !== mp.v) begin
            mismatched++;
            $display("FAIL %s cyc=%0d due=%0d got de/tick/rgb=%b/%b/%h required=%b/%b/%h",
                     mp.spot ? "pix_spot" : "pix_model", cyc, mp.due,
                     got_pix[13], got_pix[12], got_pix[11:0], mp.v[13], mp.v[12], mp.v[11:0]);
         end
      end
      while (sq.size() > 0 && sq[0].due <= cyc) begin
         ms = sq.pop_front();
         compared++;
         if (ms.due != cyc || got_st !== ms.v) begin
            mismatched++;
            $display("FAIL state cyc=%0d due=%0d got mode/cnt=%0d/%0d required=%0d/%0d",
                     cyc, ms.due, got_st[9:8], got_st[7:0], ms.v[9:8], ms.v[7:0]);
         end
      end
   end

   initial begin
      bus.DE = 1'b0; bus.x_pixel = '0; bus.y_pixel = '0;
      bus.mode_req = '0; bus.mode_req_valid = 1'b0;

      do_reset(4);

      // One line of bars with boundary spots.
      for (int x = 0; x < H; x++) begin
         if (x == 79)       spot_pix(x, 0, 12'hFFF);
         else if (x == 80)  spot_pix(x, 0, 12'hFF0);
         else if (x == 639) spot_pix(x, 0, 12'h000);
         else step(1'b1, x, 0, 0, 1'b0, 1'b0, 12'h000);
      end

      step(1'b0, 100, 100, 0, 1'b0, 1'b1, 12'h000);

      // Mode request mid-frame takes effect only at the next frame start.
      step(1'b1, 300, 10, 2, 1'b1, 1'b0, 12'h000);
      spot_pix(301, 10, 12'h0F0);
      for (int i = 0; i < 20; i++) rnd_pix(11);
      spot_pix(0, 0, 12'h000);
      spot_pix(32, 0, 12'hFFF);
      spot_pix(32, 32, 12'h000);

      request(1);
      spot_pix(0, 0, 12'h000);
      spot_pix(32, 0, 12'h111);
      spot_pix(479, 0, 12'hEEE);
      spot_pix(480, 0, 12'hFFF);
      spot_pix(639, 0, 12'hFFF);

      // Scroll: offset climbs by 2 per frame and returns to 0 after 320 frames.
      request(3);
      frame_start();
      spot_pix(78, 1, 12'hFF0);
      for (int f = 2; f <= 320; f++) begin
         frame_start();
         if (f == 319) begin
            spot_pix(1, 3, 12'h000);
            spot_pix(2, 3, 12'hFFF);
         end
         for (int i = 0; i < 3; i++) rnd_pix(1);
      end
      spot_pix(79, 7, 12'hFFF);
      spot_pix(80, 7, 12'hFF0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) frame_start();
         else step($urandom_range(0, 9) != 0, $urandom_range(0, H - 1), $urandom_range(0, V - 1),
                   $urandom_range(0, 3), $urandom_range(0, 19) == 0, 1'b0, 12'h000);
      end

      // Reset in the middle of a scrolling frame.
      request(3);
      frame_start();
      for (int i = 0; i < 10; i++) rnd_pix(1);
      do_reset(3);
      for (int i = 0; i < 10; i++) rnd_pix(1);
      frame_start();
      for (int i = 0; i < 10; i++) rnd_pix(1);

      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      compared++;
      if (pq.size() + sq.size() != 0) begin
         mismatched++;
         $display("FAIL drain leftover got=%0d required=0", pq.size() + sq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
